// File: rtl/am_demodulate_pkg.sv
// Constants and width helpers shared by the AM modulator/demodulator pair.
package am_demodulate_pkg;

  localparam int AM_DEF_IN_W  = 12;
  localparam int AM_DEF_OUT_W = 12;

  // Magnitude of a signed sample drops the sign bit.
  function automatic int mag_width(input int in_w);
    return in_w - 1;
  endfunction

  // Largest magnitude representable; the most negative input clamps here.
  function automatic int mag_max(input int in_w);
    return (1 << (in_w - 1)) - 1;
  endfunction

  function automatic int mid_scale(input int w);
    return 1 << (w - 1);
  endfunction

  function automatic int acc_width(input int in_w, input int shift);
    return mag_width(in_w) + shift;
  endfunction

endpackage

// File: rtl/am_envelope_lpf.sv
// Envelope detector: input register, saturating abs, then a leaky-integrator IIR.
module am_envelope_lpf
  import am_demodulate_pkg::*;
#(
  parameter int IN_W      = 12,
  parameter int LPF_SHIFT = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [IN_W-1:0] sample_i,
  output logic        [IN_W-2:0] envelope_o
);

  localparam int MW = mag_width(IN_W);
  localparam int AW = acc_width(IN_W, LPF_SHIFT);
  localparam logic signed [IN_W-1:0] MOST_NEG = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic [MW-1:0] MAG_SAT = MW'(mag_max(IN_W));

  logic signed [IN_W-1:0] smp_q, smp_d;
  logic [MW-1:0]          mag_q, mag_d;
  logic [AW-1:0]          acc_q, acc_d;

  always_comb begin
    smp_d = sample_i;
    if (smp_q == MOST_NEG)  mag_d = MAG_SAT;
    else if (smp_q[IN_W-1]) mag_d = MW'(-smp_q);
    else                    mag_d = smp_q[MW-1:0];
    // Leak is subtracted before the add so the sum never exceeds its fixed point.
    acc_d = acc_q - (acc_q >> LPF_SHIFT) + AW'(mag_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q <= '0;
      mag_q <= '0;
      acc_q <= '0;
    end else begin
      smp_q <= smp_d;
      mag_q <= mag_d;
      acc_q <= acc_d;
    end
  end

  assign envelope_o = acc_q[AW-1:LPF_SHIFT];

endmodule

// File: rtl/am_demodulate.sv
// AM envelope demodulator: IIR envelope, windowed DC estimate, DC-removed offset-binary output.
module am_demodulate
  import am_demodulate_pkg::*;
#(
  parameter int INPUT_WIDTH  = AM_DEF_IN_W,
  parameter int OUTPUT_WIDTH = AM_DEF_OUT_W,
  parameter int LPF_SHIFT    = 6,
  parameter int DC_WIN_LOG2  = 10
) (
  input  logic                          clk,
  input  logic                          RST_n,
  input  logic signed [INPUT_WIDTH-1:0] AM_wave,
  input  logic        [INPUT_WIDTH-2:0] present_thr,
  output logic       [OUTPUT_WIDTH-1:0] demod_wave,
  output logic        [INPUT_WIDTH-2:0] envelope,
  output logic        [INPUT_WIDTH-2:0] dc_est,
  output logic                          dc_update,
  output logic                          signal_present
);

  localparam int MW = mag_width(INPUT_WIDTH);
  localparam int SW = MW + DC_WIN_LOG2;
  localparam logic [OUTPUT_WIDTH-1:0] OUT_MID = OUTPUT_WIDTH'(mid_scale(OUTPUT_WIDTH));

  logic [MW-1:0]                 env;
  logic [DC_WIN_LOG2-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]                 sum_q, sum_d, sum_all;
  logic [MW-1:0]                 dc_q, dc_d;
  logic                          upd_q, upd_d;
  logic                          pres_q, pres_d;
  logic [OUTPUT_WIDTH-1:0]       demod_q, demod_d;
  logic signed [INPUT_WIDTH-1:0] ac;
  logic [INPUT_WIDTH-1:0]        ac_off;
  logic                          wrap;

  am_envelope_lpf #(
    .IN_W      (INPUT_WIDTH),
    .LPF_SHIFT (LPF_SHIFT)
  ) u_env (
    .clk        (clk),
    .rst_n      (RST_n),
    .sample_i   (AM_wave),
    .envelope_o (env)
  );

  always_comb begin
    wrap    = &cnt_q;
    cnt_d   = cnt_q + 1'b1;
    // The wrap-cycle envelope completes the 2^DC_WIN_LOG2-sample window.
    sum_all = sum_q + SW'(env);
    sum_d   = wrap ? '0 : sum_all;
    dc_d    = wrap ? sum_all[SW-1:DC_WIN_LOG2] : dc_q;
    upd_d   = wrap;
    pres_d  = (dc_q >= present_thr);
    ac      = signed'({1'b0, env}) - signed'({1'b0, dc_q});
    // Adding mid-scale to a two's-complement value is an MSB flip.
    ac_off  = {~ac[INPUT_WIDTH-1], ac[INPUT_WIDTH-2:0]};
  end

  generate
    if (OUTPUT_WIDTH >= INPUT_WIDTH) begin : g_widen
      assign demod_d = OUTPUT_WIDTH'(ac_off) << (OUTPUT_WIDTH - INPUT_WIDTH);
    end else begin : g_trunc
      assign demod_d = ac_off[INPUT_WIDTH-1 -: OUTPUT_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      cnt_q   <= '0;
      sum_q   <= '0;
      dc_q    <= '0;
      upd_q   <= 1'b0;
      pres_q  <= 1'b0;
      demod_q <= OUT_MID;
    end else begin
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      dc_q    <= dc_d;
      upd_q   <= upd_d;
      pres_q  <= pres_d;
      demod_q <= demod_d;
    end
  end

  assign envelope       = env;
  assign dc_est         = dc_q;
  assign dc_update      = upd_q;
  assign signal_present = pres_q;
  assign demod_wave     = demod_q;

endmodule

// File: tb/tb_am_demodulate.sv
// Directed bench for am_demodulate at default parameters.
module tb_am_demodulate;

  localparam real PI = 3.14159265358979;

  logic               clk = 1'b0;
  logic               RST_n = 1'b1;
  logic signed [11:0] AM_wave = '0;
  logic        [10:0] present_thr = 11'd100;
  logic        [11:0] demod_wave;
  logic        [10:0] envelope;
  logic        [10:0] dc_est;
  logic               dc_update;
  logic               signal_present;

  int n_chk = 0, n_err = 0, cyc = 0;
  int p1, p2, np, envbad, dembad, spbad, dcbad;
  int tsum, tmn, tmx, tmean, tv;

  always #5 clk = ~clk;

  am_demodulate #(
    .INPUT_WIDTH  (12),
    .OUTPUT_WIDTH (12),
    .LPF_SHIFT    (6),
    .DC_WIN_LOG2  (10)
  ) dut (
    .clk            (clk),
    .RST_n          (RST_n),
    .AM_wave        (AM_wave),
    .present_thr    (present_thr),
    .demod_wave     (demod_wave),
    .envelope       (envelope),
    .dc_est         (dc_est),
    .dc_update      (dc_update),
    .signal_present (signal_present)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Release lands mid-cycle, so the next rising edge is cycle 1.
  task automatic do_reset();
    RST_n = 1'b0;
    run(3);
    RST_n = 1'b1;
    cyc = 0;
  endtask

  function automatic int tone(input int n);
    real v;
    v = 500.0 * (1.0 + $sin(2.0 * PI * n / 1024.0)) * $cos(2.0 * PI * n / 8.0 + PI / 8.0);
    return int'(v);
  endfunction

  initial begin
    // reset state
    #1 RST_n = 1'b0;
    run(2);
    chk("rst_demod", demod_wave, 2048);
    chk("rst_env", envelope, 0);
    chk("rst_dc", dc_est, 0);
    chk("rst_upd", dc_update, 0);
    chk("rst_present", signal_present, 0);

    // zero input over 3000 cycles, dc_update cadence
    AM_wave = 12'sd0; present_thr = 11'd100;
    do_reset();
    p1 = -1; p2 = -1; np = 0; envbad = 0; dembad = 0; spbad = 0; dcbad = 0;
    for (int k = 1; k <= 3000; k++) begin
      tick();
      if (dc_update) begin
        np++;
        if (np == 1) p1 = cyc;
        else if (np == 2) p2 = cyc;
      end
      if (envelope != 0) envbad++;
      if (demod_wave != 12'd2048) dembad++;
      if (signal_present) spbad++;
      if (dc_est != 0) dcbad++;
    end
    chk("zero_env_bad_cycles", envbad, 0);
    chk("zero_demod_bad_cycles", dembad, 0);
    chk("zero_present_bad_cycles", spbad, 0);
    chk("zero_dc_bad_cycles", dcbad, 0);
    chk("upd_pulse_count", np, 2);
    chk("upd_first_cycle", p1, 1024);
    chk("upd_second_cycle", p2, 2048);

    // +1000 constant: latency, convergence, DC and present timing
    AM_wave = 12'sd1000; present_thr = 11'd100;
    do_reset();
    run(2);
    chk("pos_env_c2", envelope, 0);
    tick();
    chk("pos_env_c3", envelope, 15);
    run(697);
    chk("pos_env_settled", envelope, 1000);
    run(324);
    chk("pos_upd1", dc_update, 1);
    chk("pos_dc1_in_range", int'(dc_est > 11'd500 && dc_est < 11'd1000), 1);
    chk("pos_present_c1024", signal_present, 0);
    tick();
    chk("pos_upd1_width", dc_update, 0);
    chk("pos_present_c1025", signal_present, 1);
    run(1023);
    chk("pos_upd2", dc_update, 1);
    chk("pos_dc2", dc_est, 1000);
    tick();
    chk("pos_demod_centred", demod_wave, 2048);
    chk("pos_present", signal_present, 1);

    // most negative input saturates
    AM_wave = -12'sd2048;
    do_reset();
    run(3);
    chk("neg_env_c3", envelope, 31);
    run(1197);
    chk("neg_env_settled", envelope, 2047);
    run(300);
    chk("neg_env_no_wrap", envelope, 2047);

    // zero threshold: present one cycle after release
    present_thr = 11'd0;
    RST_n = 1'b0;
    run(2);
    chk("thr0_present_in_reset", signal_present, 0);
    RST_n = 1'b1; cyc = 0;
    tick();
    chk("thr0_present_c1", signal_present, 1);

    // reset 500 cycles into the second window
    AM_wave = 12'sd1000; present_thr = 11'd100;
    do_reset();
    run(1524);
    chk("mw_dc_before", int'(dc_est != 0), 1);
    chk("mw_present_before", signal_present, 1);
    #2 RST_n = 1'b0;
    #1;
    chk("mw_rst_demod", demod_wave, 2048);
    chk("mw_rst_env", envelope, 0);
    chk("mw_rst_dc", dc_est, 0);
    chk("mw_rst_upd", dc_update, 0);
    chk("mw_rst_present", signal_present, 0);
    run(2);
    RST_n = 1'b1; cyc = 0;
    while (!dc_update && cyc < 1100) tick();
    chk("mw_next_upd_cycle", cyc, 1024);

    // modulator tone looped in
    present_thr = 11'd100; AM_wave = 12'sd0;
    do_reset();
    tsum = 0; tmn = 4095; tmx = 0;
    for (int n = 1; n <= 4096; n++) begin
      tv = tone(n);
      AM_wave = tv[11:0];
      tick();
      if (n > 3072) begin
        tsum += int'(demod_wave);
        if (int'(demod_wave) < tmn) tmn = int'(demod_wave);
        if (int'(demod_wave) > tmx) tmx = int'(demod_wave);
      end
    end
    tmean = tsum / 1024;
    chk("tone_mean_within_2pct", int'(tmean >= 2007 && tmean <= 2089), 1);
    chk("tone_swing_above", int'(tmx - 2048 > 150), 1);
    chk("tone_swing_below", int'(2048 - tmn > 150), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
